// File: rtl/cmul_pp_16b.sv
// Purpose : Q1.15 complex partial-product generator (ar*wr, ai*wi, ar*wi, ai*wr) for the FFT butterfly.
// Latency : 3 cycles (operand reg -> product reg -> scaled output reg), one transfer per cycle.
// Backpr. : single global enable en = ~o_valid | i_ready; o_ready = en, all stages hold when en = 0.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_valid / o_ready          upstream handshake (o_ready is combinational on i_ready)
//   i_ar, i_ai, i_wr, i_wi     sample and twiddle, signed Q1.15
//   o_valid / i_ready          downstream handshake
//   o_rr, o_ii, o_ri, o_ir     ar*wr, ai*wi, ar*wi, ai*wr scaled to signed Q1.15
//   o_ovf / i_ovf_clr          sticky saturation flag and its synchronous clear
//
// Build option: define CMUL_ROUND_EN for round-half-up scaling; otherwise products are
// truncated (floor). Only the output scaling changes; timing and handshake are identical.
module cmul_pp_16b #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_ar,
    input  logic [DATA_WIDTH-1:0] i_ai,
    input  logic [DATA_WIDTH-1:0] i_wr,
    input  logic [DATA_WIDTH-1:0] i_wi,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_rr,
    output logic [DATA_WIDTH-1:0] o_ii,
    output logic [DATA_WIDTH-1:0] o_ri,
    output logic [DATA_WIDTH-1:0] o_ir,
    output logic                  o_ovf,
    input  logic                  i_ovf_clr
);

    localparam int PW = 2 * DATA_WIDTH;

    // -1 * -1 is the single product whose Q1.15 result does not fit.
    localparam logic signed [PW-1:0] SAT_PROD = PW'(1) << (PW - 2);
    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
`ifdef CMUL_ROUND_EN
    localparam logic signed [PW-1:0] HALF_LSB = PW'(1) << (FRAC_BITS - 1);
`endif

    // Scale a Q2.30 product to Q1.15. The saturating case is handled by the caller;
    // every other product stays in range, with or without the rounding offset.
    function automatic logic [DATA_WIDTH-1:0] scale_prod(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] adj;
`ifdef CMUL_ROUND_EN
        adj = p + HALF_LSB;
`else
        adj = p;
`endif
        if (p == SAT_PROD) begin
            scale_prod = MAX_POS;
        end else begin
            scale_prod = DATA_WIDTH'(adj >>> FRAC_BITS);
        end
    endfunction

    // ------------------------------------------------------------------
    // Global stage enable: every stage advances or holds together, so
    // bubbles travel with the data and nothing is ever collapsed.
    // ------------------------------------------------------------------
    logic en;

    // Stage 1: operand registers
    logic                         s1_vld_q, s1_vld_d;
    logic signed [DATA_WIDTH-1:0] s1_ar_q, s1_ar_d;
    logic signed [DATA_WIDTH-1:0] s1_ai_q, s1_ai_d;
    logic signed [DATA_WIDTH-1:0] s1_wr_q, s1_wr_d;
    logic signed [DATA_WIDTH-1:0] s1_wi_q, s1_wi_d;

    // Stage 2: full-precision Q2.30 products
    logic                 s2_vld_q, s2_vld_d;
    logic signed [PW-1:0] s2_rr_q, s2_rr_d;
    logic signed [PW-1:0] s2_ii_q, s2_ii_d;
    logic signed [PW-1:0] s2_ri_q, s2_ri_d;
    logic signed [PW-1:0] s2_ir_q, s2_ir_d;

    // Stage 3: scaled outputs and flags
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] rr_q, rr_d;
    logic [DATA_WIDTH-1:0] ii_q, ii_d;
    logic [DATA_WIDTH-1:0] ri_q, ri_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic                  ovf_q, ovf_d;

    logic s2_sat;
    logic ovf_set;

    assign en      = ~out_vld_q | i_ready;
    assign o_ready = en;

    always_comb begin
        // hold by default
        s1_vld_d  = s1_vld_q;
        s1_ar_d   = s1_ar_q;
        s1_ai_d   = s1_ai_q;
        s1_wr_d   = s1_wr_q;
        s1_wi_d   = s1_wi_q;
        s2_vld_d  = s2_vld_q;
        s2_rr_d   = s2_rr_q;
        s2_ii_d   = s2_ii_q;
        s2_ri_d   = s2_ri_q;
        s2_ir_d   = s2_ir_q;
        out_vld_d = out_vld_q;
        rr_d      = rr_q;
        ii_d      = ii_q;
        ri_d      = ri_q;
        ir_d      = ir_q;

        if (en) begin
            s1_vld_d  = i_valid;
            s1_ar_d   = i_ar;
            s1_ai_d   = i_ai;
            s1_wr_d   = i_wr;
            s1_wi_d   = i_wi;

            s2_vld_d  = s1_vld_q;
            s2_rr_d   = s1_ar_q * s1_wr_q;
            s2_ii_d   = s1_ai_q * s1_wi_q;
            s2_ri_d   = s1_ar_q * s1_wi_q;
            s2_ir_d   = s1_ai_q * s1_wr_q;

            out_vld_d = s2_vld_q;
            rr_d      = scale_prod(s2_rr_q);
            ii_d      = scale_prod(s2_ii_q);
            ri_d      = scale_prod(s2_ri_q);
            ir_d      = scale_prod(s2_ir_q);
        end
    end

    // Saturation only counts when a real sample is loaded into the output stage.
    always_comb begin
        s2_sat  = (s2_rr_q == SAT_PROD) | (s2_ii_q == SAT_PROD) |
                  (s2_ri_q == SAT_PROD) | (s2_ir_q == SAT_PROD);
        ovf_set = en & s2_vld_q & s2_sat;

        // set wins over a coincident clear
        ovf_d = ovf_q;
        if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_ar_q   <= '0;
            s1_ai_q   <= '0;
            s1_wr_q   <= '0;
            s1_wi_q   <= '0;
            s2_vld_q  <= 1'b0;
            s2_rr_q   <= '0;
            s2_ii_q   <= '0;
            s2_ri_q   <= '0;
            s2_ir_q   <= '0;
            out_vld_q <= 1'b0;
            rr_q      <= '0;
            ii_q      <= '0;
            ri_q      <= '0;
            ir_q      <= '0;
            ovf_q     <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_ar_q   <= s1_ar_d;
            s1_ai_q   <= s1_ai_d;
            s1_wr_q   <= s1_wr_d;
            s1_wi_q   <= s1_wi_d;
            s2_vld_q  <= s2_vld_d;
            s2_rr_q   <= s2_rr_d;
            s2_ii_q   <= s2_ii_d;
            s2_ri_q   <= s2_ri_d;
            s2_ir_q   <= s2_ir_d;
            out_vld_q <= out_vld_d;
            rr_q      <= rr_d;
            ii_q      <= ii_d;
            ri_q      <= ri_d;
            ir_q      <= ir_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_valid = out_vld_q;
    assign o_rr    = rr_q;
    assign o_ii    = ii_q;
    assign o_ri    = ri_q;
    assign o_ir    = ir_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_cmul_pp_16b.sv
// Purpose : directed self-checking bench for cmul_pp_16b.
// Latency : checks 3-cycle latency and back-to-back throughput.
// Backpr. : drives i_ready low mid-stream and checks stall/hold/ordering.
module tb_cmul_pp_16b;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_ar, i_ai, i_wr, i_wi;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_rr, o_ii, o_ri, o_ir;
    logic        o_ovf;
    logic        i_ovf_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmul_pp_16b dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_ar      (i_ar),
        .i_ai      (i_ai),
        .i_wr      (i_wr),
        .i_wi      (i_wi),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_rr      (o_rr),
        .o_ii      (o_ii),
        .o_ri      (o_ri),
        .o_ir      (o_ir),
        .o_ovf     (o_ovf),
        .i_ovf_clr (i_ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ar, input logic [15:0] ai,
                         input logic [15:0] wr, input logic [15:0] wi);
        i_valid = v;
        i_ar    = ar;
        i_ai    = ai;
        i_wr    = wr;
        i_wi    = wi;
    endtask

    // Hard stop if something wedges the sequence.
    initial begin
        #200000;
        $display("FAIL timeout: observed no end of sequence, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] exp_r1, exp_r2;
        logic [15:0] held;
        bit          have_held;
        bit          acc;
        int          sent, recv, vcount;

`ifdef CMUL_ROUND_EN
        exp_r1 = 16'h0001;
        exp_r2 = 16'h0000;
`else
        exp_r1 = 16'h0000;
        exp_r2 = 16'hFFFF;
`endif

        // ---------------- reset state ----------------
        rst_n     = 1'b0;
        i_ready   = 1'b1;
        i_ovf_clr = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_rr", o_rr, 16'h0000);
        chk("rst_ii", o_ii, 16'h0000);
        chk("rst_ri", o_ri, 16'h0000);
        chk("rst_ir", o_ir, 16'h0000);
        chk("rst_ovf", o_ovf, 0);
        chk("rst_ready", o_ready, 1);
        rst_n = 1'b1;
        tick();

        // ---------------- basic product + latency ----------------
        drive(1'b1, 16'h4000, 16'h2000, 16'h4000, 16'hC000);
        tick();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        chk("lat_not_early", o_valid, 0);
        tick();
        chk("basic_valid", o_valid, 1);
        chk("basic_rr", o_rr, 16'h2000);
        chk("basic_ii", o_ii, 16'hF000);
        chk("basic_ri", o_ri, 16'hE000);
        chk("basic_ir", o_ir, 16'h1000);
        chk("basic_ovf", o_ovf, 0);
        tick();
        chk("basic_drain", o_valid, 0);

        // ---------------- rounding boundary, back to back ----------------
        drive(1'b1, 16'h0001, 16'h0, 16'h4000, 16'h0);
        tick();
        drive(1'b1, 16'hFFFF, 16'h0, 16'h4000, 16'h0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        chk("rnd_pos_valid", o_valid, 1);
        chk("rnd_pos_rr", o_rr, exp_r1);
        tick();
        chk("rnd_neg_valid", o_valid, 1);
        chk("rnd_neg_rr", o_rr, exp_r2);
        tick();

        // ---------------- saturation inside a bubble is ignored ----------------
        drive(1'b0, 16'h8000, 16'h0, 16'h8000, 16'h0);
        tick();
        tick();
        tick();
        tick();
        chk("bubble_sat_ovf", o_ovf, 0);
        chk("bubble_sat_valid", o_valid, 0);

        // ---------------- saturation ----------------
        drive(1'b1, 16'h8000, 16'h0, 16'h8000, 16'h0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        tick();
        chk("sat_valid", o_valid, 1);
        chk("sat_rr", o_rr, 16'h7FFF);
        chk("sat_ii", o_ii, 16'h0000);
        chk("sat_ovf", o_ovf, 1);
        tick();
        chk("sat_sticky", o_ovf, 1);
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        chk("ovf_clear", o_ovf, 0);

        // set beats a clear landing on the same edge
        drive(1'b1, 16'h8000, 16'h0, 16'h8000, 16'h0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        chk("ovf_set_prio", o_ovf, 1);
        tick();

        // ---------------- backpressure ----------------
        sent      = 0;
        recv      = 0;
        have_held = 1'b0;
        held      = 16'h0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            i_ready = !(cyc >= 5 && cyc < 9);
            if (sent < 6) begin
                drive(1'b1, 16'((sent + 1) * 16'h1000), 16'h0, 16'h4000, 16'h2000);
            end else begin
                drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
            end
            #1;
            if (o_valid && i_ready) begin
                chk("bp_rr", o_rr, 16'((recv + 1) * 16'h0800));
                chk("bp_ri", o_ri, 16'((recv + 1) * 16'h0400));
                recv++;
            end
            if (o_valid && !i_ready) begin
                chk("bp_ready_low", o_ready, 0);
                if (have_held) begin
                    chk("bp_hold", o_rr, held);
                end
                held      = o_rr;
                have_held = 1'b1;
            end
            acc = i_valid && o_ready;
            tick();
            if (acc) sent++;
        end
        i_ready = 1'b1;
        chk("bp_recv_count", recv, 6);
        chk("bp_sent_count", sent, 6);
        chk("bp_drained", o_valid, 0);

        // ---------------- reset mid-stream ----------------
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 16'h8000, 16'h1234, 16'h8000, 16'h4321);
            tick();
        end
        chk("mid_pre_valid", o_valid, 1);
        chk("mid_pre_ovf", o_ovf, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_rr", o_rr, 16'h0000);
        chk("mid_rst_ii", o_ii, 16'h0000);
        chk("mid_rst_ovf", o_ovf, 0);
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", o_ready, 1);
        vcount = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (o_valid) vcount++;
        end
        chk("mid_no_ghosts", vcount, 0);
        chk("mid_ovf_after", o_ovf, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
